// File: rtl/instr_register_sched.sv
// instr_register_sched: round-robin write arbiter and FIFO read sequencer for the instruction register.
// Zero-fills every entry after reset or flush before any traffic is accepted.
module instr_register_sched #(
    parameter int NUM_REQ = 4,
    parameter int DEPTH   = 32,
    parameter int PTR_W   = $clog2(DEPTH),
    parameter int OP_W    = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*4-1:0]       req_opcode,
    input  logic [NUM_REQ*OP_W-1:0]    req_operand_a,
    input  logic [NUM_REQ*OP_W-1:0]    req_operand_b,
    output logic                       ir_load_en,
    output logic [PTR_W-1:0]           ir_write_pointer,
    output logic [3:0]                 ir_opcode,
    output logic [OP_W-1:0]            ir_operand_a,
    output logic [OP_W-1:0]            ir_operand_b,
    output logic [PTR_W-1:0]           ir_read_pointer,
    output logic                       ex_valid,
    input  logic                       ex_ready,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic [PTR_W:0]             count,
    output logic                       full,
    output logic                       empty,
    output logic                       init_done
);
    localparam int GW = $clog2(NUM_REQ);
    localparam logic [0:0] INIT = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;
    localparam logic [PTR_W:0] FULL_C = (PTR_W+1)'(DEPTH);

    logic [0:0]      state_q, state_d;
    logic [PTR_W-1:0] k_q, k_d, wr_q, wr_d, rd_q, rd_d, wp_q, wp_d;
    logic [GW-1:0]   rr_q, rr_d, gid_q, gid_d, gnt_idx;
    logic [PTR_W:0]  count_q, count_d, commit_q, commit_d;
    logic            load_q, load_d;
    logic [3:0]      op_q, op_d;
    logic [OP_W-1:0] a_q, a_d, b_q, b_d;
    logic            run, in_init, found, xfer, pop;

    assign run       = state_q == RUN;
    assign in_init   = !run && !reset;
    assign full      = count_q == FULL_C;
    assign empty     = count_q == '0;
    assign init_done = run;
    assign ex_valid  = run && commit_q != '0;
    assign pop       = ex_valid && ex_ready;
    // a flush/reset cycle must not handshake, since the grant would be discarded
    assign xfer      = run && !flush && !reset && !full && found;
    assign req_ready = xfer ? NUM_REQ'(1) << gnt_idx : '0;

    assign ir_load_en       = in_init || load_q;
    assign ir_write_pointer = in_init ? k_q : wp_q;
    assign ir_opcode        = op_q;
    assign ir_operand_a     = a_q;
    assign ir_operand_b     = b_q;
    assign ir_read_pointer  = rd_q;
    assign grant_id         = gid_q;
    assign count            = count_q;

    // descending scan so the requester closest to the rr pointer wins
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (req_valid[GW'((int'(rr_q) + j) % NUM_REQ)]) begin
                found   = 1'b1;
                gnt_idx = GW'((int'(rr_q) + j) % NUM_REQ);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        rr_d     = rr_q;
        gid_d    = gid_q;
        wr_d     = wr_q;
        rd_d     = rd_q;
        wp_d     = wp_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        load_d   = xfer;
        count_d  = count_q + (PTR_W+1)'(xfer) - (PTR_W+1)'(pop);
        commit_d = commit_q + (PTR_W+1)'(run && load_q) - (PTR_W+1)'(pop);
        if (!run) begin
            k_d     = k_q + 1'b1;
            state_d = k_q == PTR_W'(DEPTH - 1) ? RUN : INIT;
        end
        if (xfer) begin
            rr_d  = gnt_idx == GW'(NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
            gid_d = gnt_idx;
            wr_d  = wr_q + 1'b1;
            wp_d  = wr_q;
            op_d  = req_opcode[4*gnt_idx +: 4];
            a_d   = req_operand_a[OP_W*gnt_idx +: OP_W];
            b_d   = req_operand_b[OP_W*gnt_idx +: OP_W];
        end
        if (pop) rd_d = rd_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state_q  <= INIT;
            k_q      <= '0;
            rr_q     <= '0;
            gid_q    <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            wp_q     <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            load_q   <= 1'b0;
            count_q  <= '0;
            commit_q <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            rr_q     <= rr_d;
            gid_q    <= gid_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            wp_q     <= wp_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            load_q   <= load_d;
            count_q  <= count_d;
            commit_q <= commit_d;
        end
    end
endmodule

// File: tb/tb_instr_register_sched.sv
// tb_instr_register_sched: random traffic against a queue-based FIFO/round-robin model.
module tb_instr_register_sched;
    localparam int N = 4, D = 32, PW = 5, OW = 32;

    logic            clk = 1'b0, reset = 1'b1, flush = 1'b0, ex_ready = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*4-1:0]  req_opcode = '0;
    logic [N*OW-1:0] req_operand_a = '0, req_operand_b = '0;
    logic            ir_load_en, ex_valid, full, empty, init_done;
    logic [PW-1:0]   ir_write_pointer, ir_read_pointer;
    logic [3:0]      ir_opcode;
    logic [OW-1:0]   ir_operand_a, ir_operand_b;
    logic [1:0]      grant_id;
    logic [PW:0]     count;

    instr_register_sched dut (
        .clk(clk), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
        .req_operand_a(req_operand_a), .req_operand_b(req_operand_b),
        .ir_load_en(ir_load_en), .ir_write_pointer(ir_write_pointer), .ir_opcode(ir_opcode),
        .ir_operand_a(ir_operand_a), .ir_operand_b(ir_operand_b), .ir_read_pointer(ir_read_pointer),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .grant_id(grant_id), .count(count),
        .full(full), .empty(empty), .init_done(init_done)
    );

    always #5 clk = ~clk;

    typedef struct { logic [3:0] op; logic [OW-1:0] a; logic [OW-1:0] b; int slot; int cyc; } ent_t;

    ent_t        q[$];
    ent_t        m_ld;
    logic [67:0] mem [D];
    int          total = 0, bad = 0, cyc = 0;
    int          mrr = 0, mwp = 0, mrp = 0, mgid = 0, mk = 0;
    bit          phase_init = 1'b1, m_ld_v = 1'b0, to_flag = 1'b0;

    task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h cyc=%0d", n, act, exp, cyc);
        end
    endtask

    // monitor + reference model: grants push expected entries, pops compare and retire them
    always @(negedge clk) begin
        int g;
        bit ev;
        ent_t e;
        cyc++;
        g  = -1;
        ev = 1'b0;
        chk("wait_timeout", 128'(to_flag), 128'(0));
        if (ir_load_en && !reset) mem[ir_write_pointer] = {ir_opcode, ir_operand_a, ir_operand_b};
        if (reset) begin
            chk("rst_load", 128'(ir_load_en), 0);
            chk("rst_wptr", 128'(ir_write_pointer), 0);
            chk("rst_rptr", 128'(ir_read_pointer), 0);
            chk("rst_op", {ir_opcode, ir_operand_a, ir_operand_b}, 0);
            chk("rst_exv", 128'(ex_valid), 0);
            chk("rst_ready", 128'(req_ready), 0);
            chk("rst_gid", 128'(grant_id), 0);
            chk("rst_count", 128'(count), 0);
            chk("rst_empty_full", {empty, full}, 128'(2'b10));
            chk("rst_init_done", 128'(init_done), 0);
        end else if (phase_init) begin
            chk("init_load", 128'(ir_load_en), 1);
            chk("init_wptr", 128'(ir_write_pointer), 128'(mk));
            chk("init_data", {ir_opcode, ir_operand_a, ir_operand_b}, 0);
            chk("init_ready", 128'(req_ready), 0);
            chk("init_exv", 128'(ex_valid), 0);
            chk("init_done_lo", 128'(init_done), 0);
            chk("init_count", 128'(count), 0);
        end else begin
            if (!flush && q.size() < D)
                for (int j = 0; j < N; j++)
                    if (g < 0 && req_valid[(mrr + j) % N]) g = (mrr + j) % N;
            chk("req_ready", 128'(req_ready), g >= 0 ? 128'(1) << g : 128'(0));
            chk("count", 128'(count), 128'(q.size()));
            chk("full", 128'(full), 128'(q.size() == D));
            chk("empty", 128'(empty), 128'(q.size() == 0));
            chk("grant_id", 128'(grant_id), 128'(mgid));
            chk("init_done", 128'(init_done), 1);
            chk("load_en", 128'(ir_load_en), 128'(m_ld_v));
            if (m_ld_v) begin
                chk("load_ptr", 128'(ir_write_pointer), 128'(m_ld.slot));
                chk("load_data", {ir_opcode, ir_operand_a, ir_operand_b}, {m_ld.op, m_ld.a, m_ld.b});
            end
            ev = q.size() > 0 && q[0].cyc <= cyc - 2;
            chk("ex_valid", 128'(ex_valid), 128'(ev));
            chk("rd_ptr", 128'(ir_read_pointer), 128'(mrp));
            if (ev && ex_ready && !flush)
                chk("pop_data", 128'(mem[ir_read_pointer]), {q[0].op, q[0].a, q[0].b});
        end
        if (reset || flush) begin
            phase_init = 1'b1;
            mk = 0; mrr = 0; mwp = 0; mrp = 0; mgid = 0; m_ld_v = 1'b0;
            q.delete();
        end else if (phase_init) begin
            mk++;
            if (mk == D) phase_init = 1'b0;
        end else begin
            m_ld_v = 1'b0;
            if (g >= 0) begin
                e.op = req_opcode[4*g +: 4];
                e.a = req_operand_a[OW*g +: OW];
                e.b = req_operand_b[OW*g +: OW];
                e.slot = mwp;
                e.cyc = cyc;
                q.push_back(e);
                m_ld = e;
                m_ld_v = 1'b1;
                mwp = (mwp + 1) % D;
                mrr = (g + 1) % N;
                mgid = g;
            end
            if (ev && ex_ready) begin
                void'(q.pop_front());
                mrp = (mrp + 1) % D;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [N-1:0] v, input logic er);
        req_valid     = v;
        ex_ready      = er;
        req_opcode    = 16'($urandom);
        req_operand_a = {$urandom, $urandom, $urandom, $urandom};
        req_operand_b = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_init();
        for (int i = 0; i < 40 && !init_done; i++) step();
        if (!init_done) to_flag = 1'b1;
    endtask

    initial begin
        drive('0, 1'b0);
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        wait_init();
        drive(4'b0100, 1'b1);
        req_opcode    = 16'h0100;
        req_operand_a = 128'(5) << 64;
        req_operand_b = 128'(3) << 64;
        step();
        drive('0, 1'b1);
        repeat (4) step();
        for (int i = 0; i < 40; i++) begin drive(4'hF, 1'b0); step(); end
        drive(4'hF, 1'b1);
        step();
        for (int i = 0; i < 3; i++) begin drive(4'hF, 1'b0); step(); end
        for (int i = 0; i < 40; i++) begin drive('0, 1'b1); step(); end
        for (int i = 0; i < 40; i++) begin drive(4'b1 << $urandom_range(0, 3), 1'b1); step(); end
        for (int i = 0; i < 200; i++) begin drive(4'($urandom), 1'($urandom)); step(); end
        for (int i = 0; i < 40; i++) begin drive('0, 1'b1); step(); end
        for (int i = 0; i < 50 && count != 7; i++) begin drive(4'hF, 1'b0); step(); end
        if (count != 7) to_flag = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive('0, 1'b0);
        repeat (34) step();
        for (int i = 0; i < 100; i++) begin drive(4'($urandom), 1'($urandom)); step(); end
        for (int i = 0; i < 40; i++) begin drive('0, 1'b1); step(); end
        repeat (2) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instr_register_sched.md
Name: instr_register_sched

Overview:
- Controller in front of the 32-entry instruction register (instr_register).
- Arbitrates up to NUM_REQ instruction producers round-robin onto the register's single write port and allocates write pointers circularly.
- Sequences read pointers to one execute consumer with valid/ready, so the register operates as an arbitrated FIFO.
- On reset or flush, zero-fills every register entry before accepting traffic.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
DEPTH, 32, instruction register entries (power of 2)
PTR_W, $clog2(DEPTH), pointer width
OP_W, 32, operand width (signed)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
flush  in  1  restart INIT sequence; same effect as reset
req_valid  in  NUM_REQ  per-requester instruction valid
req_ready  out  NUM_REQ  per-requester grant (one-hot or zero)
req_opcode  in  NUM_REQ*4  packed opcodes, requester i at [4i+3:4i]
req_operand_a  in  NUM_REQ*OP_W  packed operand A
req_operand_b  in  NUM_REQ*OP_W  packed operand B
ir_load_en  out  1  write strobe to instruction register
ir_write_pointer  out  PTR_W  write address
ir_opcode  out  4  write opcode
ir_operand_a  out  OP_W  write operand A
ir_operand_b  out  OP_W  write operand B
ir_read_pointer  out  PTR_W  read address (register read is combinational)
ex_valid  out  1  entry at ir_read_pointer is committed and readable
ex_ready  in  1  consumer accepts entry
grant_id  out  $clog2(NUM_REQ)  index of last granted requester
count  out  PTR_W+1  allocated entries
full  out  1  count==DEPTH
empty  out  1  count==0
init_done  out  1  high in RUN state

Behaviour:
- Reset values: all ir_* outputs 0, ex_valid 0, req_ready 0, grant_id 0, count 0, empty 1, full 0, init_done 0, state INIT, rr priority at requester 0.
- FSM states: INIT, RUN.
- INIT: init index k counts 0..DEPTH-1.
  - Each cycle drives ir_load_en=1, ir_write_pointer=k, opcode ZERO (4'd0), operands 0.
  - After k=DEPTH-1 the FSM enters RUN the next cycle, with wr_ptr=rd_ptr=0.
  - INIT lasts exactly DEPTH cycles. req_ready=0 and ex_valid=0 throughout.
- RUN, grant:
  - req_ready is combinational: one-hot for the first valid requester at or after the rr pointer, only when count<DEPTH; otherwise all zero.
  - A transfer occurs on req_valid[i]&req_ready[i].
  - On a transfer the rr pointer moves to (i+1) mod NUM_REQ and grant_id<=i.
- Write latency:
  - The granted instruction is registered onto ir_* with ir_load_en=1 in the cycle after the grant, at ir_write_pointer=wr_ptr.
  - wr_ptr increments mod DEPTH (wraps 31->0).
  - ir_load_en=0 in cycles with no grant.
- Commit tracking:
  - alloc count (the count output) increments at the grant.
  - commit count increments when ir_load_en (RUN) is high.
  - Both decrement on pop.
- Read side:
  - ex_valid = (commit count != 0) in RUN.
  - ir_read_pointer=rd_ptr, held stable while ex_valid && !ex_ready.
  - Pop on ex_valid&ex_ready: rd_ptr increments mod DEPTH.
  - First readable cycle is 2 cycles after the grant (grant, load, visible).
- Simultaneous grant and pop: count unchanged; both pointers advance.
- Full behaviour: a pop while full frees a slot only from the next cycle; req_ready stays 0 in the pop cycle.
- Full/empty: combinational from count.
- flush or reset mid-operation: in-flight grants and un-popped entries are discarded. Next cycle state is INIT, k=0, count 0, pointers 0, outputs at reset values except ir_* driven by INIT. reset has priority over flush.
- Opcodes pass through unmodified; no decode.

Test Plan:
- Reset asserted 2 cycles, then released -> exactly 32 consecutive ir_load_en pulses, pointers 0..31, opcode 0, operands 0. init_done rises on cycle 33. req_ready=0 during INIT.
- Requester 2 only: ADD, a=5, b=3, ex_ready=1 -> grant cycle T; T+1 ir_load_en, ptr 0, opcode ADD, a=5, b=3; T+2 ex_valid=1, read_ptr 0; count 1 then 0.
- All 4 requesters valid continuously, ex_ready=0 -> grant order 0,1,2,3,0,... ; grant_id follows. After 32 grants full=1, count=32, req_ready=0.
- From full, ex_ready=1 for one cycle -> rd_ptr=1, count=31; one further grant writes ptr 0 (wrap).
- Run 40 single-requester instructions with ex_ready=1 -> wr/rd pointers wrap 31->0; ex_valid opcodes pop in issue order.
- flush while count=7 and a grant in flight -> next cycle INIT with k=0; 32 zero writes, count=0, ex_valid=0; no stale instruction popped afterward.
